// File: rtl/fp_align_stage.sv
// rtl/fp_align_stage.sv - two-stage IEEE-754 single operand compare/swap/align pipeline
module fp_align_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        in_vld,
    output logic        in_rdy,
    output logic        out_vld,
    input  logic        out_rdy,
    output logic [7:0]  exp_big,
    output logic        sign_big,
    output logic        sign_small,
    output logic [23:0] mant_big,
    output logic [23:0] mant_small,
    output logic        sticky
);

    // Operand unpack: zero/denormal exponent flushes the mantissa to zero.
    logic [7:0]  w_exp_a;
    logic [7:0]  w_exp_b;
    logic [23:0] w_mant_a;
    logic [23:0] w_mant_b;
    logic        w_a_big;
    logic [7:0]  w_shamt;

    assign w_exp_a  = op_a[30:23];
    assign w_exp_b  = op_b[30:23];
    assign w_mant_a = (w_exp_a == 8'd0) ? 24'd0 : {1'b1, op_a[22:0]};
    assign w_mant_b = (w_exp_b == 8'd0) ? 24'd0 : {1'b1, op_b[22:0]};

    // Magnitude order on {exponent, mantissa}; ties leave A as the big operand.
    assign w_a_big  = ({w_exp_a, w_mant_a} >= {w_exp_b, w_mant_b});
    assign w_shamt  = w_a_big ? (w_exp_a - w_exp_b) : (w_exp_b - w_exp_a);

    // Stage 1 state
    logic        r_s1_vld;
    logic [7:0]  r_s1_exp_big;
    logic        r_s1_sign_big;
    logic        r_s1_sign_small;
    logic [23:0] r_s1_mant_big;
    logic [23:0] r_s1_mant_small;
    logic [7:0]  r_s1_shamt;

    // Stage 2 state
    logic        r_s2_vld;
    logic [7:0]  r_s2_exp_big;
    logic        r_s2_sign_big;
    logic        r_s2_sign_small;
    logic [23:0] r_s2_mant_big;
    logic [23:0] r_s2_mant_small;
    logic        r_s2_sticky;

    // Handshake: a stage advances when the next one is empty or draining now.
    logic w_s2_free;
    logic w_s1_adv;
    logic w_in_xfer;

    assign w_s2_free = !r_s2_vld || out_rdy;
    assign w_s1_adv  = r_s1_vld && w_s2_free;
    assign in_rdy    = !r_s1_vld || w_s1_adv;
    assign w_in_xfer = in_vld && in_rdy;

    // Alignment shifter: clamping the amount at 24 pushes the whole mantissa
    // into the guard half, so the sticky OR covers every discarded bit.
    logic [4:0]  w_sh_clamp;
    logic [47:0] w_wide;

    assign w_sh_clamp = (r_s1_shamt >= 8'd24) ? 5'd24 : r_s1_shamt[4:0];
    assign w_wide     = {r_s1_mant_small, 24'd0} >> w_sh_clamp;

    // Stage 1: capture compare/swap result and shift amount on input transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld        <= 1'b0;
            r_s1_exp_big    <= 8'd0;
            r_s1_sign_big   <= 1'b0;
            r_s1_sign_small <= 1'b0;
            r_s1_mant_big   <= 24'd0;
            r_s1_mant_small <= 24'd0;
            r_s1_shamt      <= 8'd0;
        end else begin
            if (w_in_xfer) begin
                r_s1_vld        <= 1'b1;
                r_s1_exp_big    <= w_a_big ? w_exp_a  : w_exp_b;
                r_s1_sign_big   <= w_a_big ? op_a[31] : op_b[31];
                r_s1_sign_small <= w_a_big ? op_b[31] : op_a[31];
                r_s1_mant_big   <= w_a_big ? w_mant_a : w_mant_b;
                r_s1_mant_small <= w_a_big ? w_mant_b : w_mant_a;
                r_s1_shamt      <= w_shamt;
            end else if (w_s1_adv) begin
                r_s1_vld        <= 1'b0;
            end
        end
    end

    // Stage 2: capture shifted mantissa and sticky when stage 1 advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s2_vld        <= 1'b0;
            r_s2_exp_big    <= 8'd0;
            r_s2_sign_big   <= 1'b0;
            r_s2_sign_small <= 1'b0;
            r_s2_mant_big   <= 24'd0;
            r_s2_mant_small <= 24'd0;
            r_s2_sticky     <= 1'b0;
        end else begin
            if (w_s1_adv) begin
                r_s2_vld        <= 1'b1;
                r_s2_exp_big    <= r_s1_exp_big;
                r_s2_sign_big   <= r_s1_sign_big;
                r_s2_sign_small <= r_s1_sign_small;
                r_s2_mant_big   <= r_s1_mant_big;
                r_s2_mant_small <= w_wide[47:24];
                r_s2_sticky     <= |w_wide[23:0];
            end else if (out_rdy) begin
                r_s2_vld        <= 1'b0;
            end
        end
    end

    assign out_vld    = r_s2_vld;
    assign exp_big    = r_s2_exp_big;
    assign sign_big   = r_s2_sign_big;
    assign sign_small = r_s2_sign_small;
    assign mant_big   = r_s2_mant_big;
    assign mant_small = r_s2_mant_small;
    assign sticky     = r_s2_sticky;

endmodule

// File: tb/tb_fp_align_stage.sv
// tb/tb_fp_align_stage.sv - self-checking bench for fp_align_stage
module tb_fp_align_stage;

    logic        clk;
    logic        rst;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        in_vld;
    logic        in_rdy;
    logic        out_vld;
    logic        out_rdy;
    logic [7:0]  exp_big;
    logic        sign_big;
    logic        sign_small;
    logic [23:0] mant_big;
    logic [23:0] mant_small;
    logic        sticky;

    fp_align_stage dut (
        .clk        (clk),
        .rst        (rst),
        .op_a       (op_a),
        .op_b       (op_b),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .out_vld    (out_vld),
        .out_rdy    (out_rdy),
        .exp_big    (exp_big),
        .sign_big   (sign_big),
        .sign_small (sign_small),
        .mant_big   (mant_big),
        .mant_small (mant_small),
        .sticky     (sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit rand_rdy = 1'b0;

    logic [58:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
        end
    endtask

    function automatic logic [58:0] pack_out();
        return {sign_big, sign_small, exp_big, mant_big, mant_small, sticky};
    endfunction

    // Reference: plain integer arithmetic on unpacked operand fields.
    function automatic logic [58:0] ref_model(input logic [31:0] a, input logic [31:0] b);
        int ea, eb, ma, mb, eb_big, es, mbig, ms, d, small_v;
        bit sa, sb, sbig, ssm, a_big, st;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        sa = a[31];
        sb = b[31];
        ma = (ea == 0) ? 0 : (1 << 23) + int'(a[22:0]);
        mb = (eb == 0) ? 0 : (1 << 23) + int'(b[22:0]);
        a_big = (ea > eb) || (ea == eb && ma >= mb);
        eb_big = a_big ? ea : eb;
        es     = a_big ? eb : ea;
        mbig   = a_big ? ma : mb;
        ms     = a_big ? mb : ma;
        sbig   = a_big ? sa : sb;
        ssm    = a_big ? sb : sa;
        d = eb_big - es;
        if (d >= 24) begin
            small_v = 0;
            st = (ms != 0);
        end else begin
            small_v = ms / (1 << d);
            st = (ms % (1 << d)) != 0;
        end
        return {sbig, ssm, eb_big[7:0], mbig[23:0], small_v[23:0], st};
    endfunction

    // Scoreboard: record accepted inputs, compare each drained output in order,
    // and verify outputs stay frozen while stalled.
    bit          stall_prev = 1'b0;
    logic [58:0] prev_pkt;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_vld", 64'(out_vld), 64'd1);
                check("hold_data", 64'(pack_out()), 64'(prev_pkt));
            end
            if (out_vld && out_rdy) begin
                if (exp_q.size() == 0) check("spurious_out", 64'd1, 64'd0);
                else check("result", 64'(pack_out()), 64'(exp_q.pop_front()));
            end
            if (in_vld && in_rdy) exp_q.push_back(ref_model(op_a, op_b));
            stall_prev = out_vld && !out_rdy;
            prev_pkt   = pack_out();
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_rdy = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        bit got;
        int k;
        op_a = a;
        op_b = b;
        in_vld = 1'b1;
        k = 0;
        got = 1'b0;
        do begin
            @(negedge clk);
            got = in_rdy;
            @(posedge clk);
            #1;
            k++;
        end while (!got && k < 200);
        if (!got) check("send_timeout", 64'd0, 64'd1);
        in_vld = 1'b0;
    endtask

    task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic [7:0] e_exp,
                            input logic [23:0] e_mb, input logic [23:0] e_ms, input logic e_st,
                            input logic e_ssm);
        send(a, b);
        check("lat_cycle1", 64'(out_vld), 64'd0);
        @(posedge clk);
        #1;
        check("lat_cycle2", 64'(out_vld), 64'd1);
        check("dir_exp", 64'(exp_big), 64'(e_exp));
        check("dir_mbig", 64'(mant_big), 64'(e_mb));
        check("dir_msmall", 64'(mant_small), 64'(e_ms));
        check("dir_sticky", 64'(sticky), 64'(e_st));
        check("dir_ssmall", 64'(sign_small), 64'(e_ssm));
        check("dir_sbig", 64'(sign_big), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops(output logic [31:0] a, output logic [31:0] b);
        logic [31:0] r;
        int e;
        a = $urandom;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: b = $urandom;
            1: begin
                e = int'(a[30:23]) - int'($urandom_range(0, 27));
                if (e < 0) e = 0;
                b = {r[31], e[7:0], r[22:0]};
            end
            2: b = {r[31], 8'd0, r[22:0]};
            default: b = {r[31], a[30:23], ($urandom_range(0, 1) != 0) ? a[22:0] : r[22:0]};
        endcase
        if ($urandom_range(0, 1) != 0) begin
            r = a;
            a = b;
            b = r;
        end
    endtask

    initial begin
        logic [31:0] a, b;
        int k;
        rst = 1'b1;
        op_a = 32'h3F80_0000;
        op_b = 32'h4000_0000;
        in_vld = 1'b1;
        out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_vld", 64'(out_vld), 64'd0);
        check("rst_outputs", 64'(pack_out()), 64'd0);
        rst = 1'b0;
        in_vld = 1'b0;
        check("rst_in_rdy", 64'(in_rdy), 64'd1);

        directed(32'h3F80_0000, 32'h4000_0000, 8'h80, 24'h800000, 24'h400000, 1'b0, 1'b0);
        directed(32'h4B80_0000, 32'h3F80_0001, 8'h97, 24'h800000, 24'h000000, 1'b1, 1'b0);
        directed(32'h7F00_0000, 32'hBF80_0000, 8'hFE, 24'h800000, 24'h000000, 1'b1, 1'b1);
        directed(32'h3F80_0000, 32'h0000_0001, 8'h7F, 24'h800000, 24'h000000, 1'b0, 1'b0);

        // Backpressure: two ops fill both stages, then the input must stall.
        out_rdy = 1'b0;
        send(32'h4120_0000, 32'h3F00_0000);
        send(32'h4480_0123, 32'hC47F_FFFF);
        check("bp_in_rdy_low", 64'(in_rdy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("bp_still_full", 64'(in_rdy), 64'd0);
        out_rdy = 1'b1;
        send(32'h3F80_0000, 32'h3F80_0000);
        send(32'h0000_0000, 32'h8000_0000);
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("bp_drain", 64'(exp_q.size()), 64'd0);

        // Reset with two ops in flight: nothing may emerge afterwards.
        send(32'h4000_0000, 32'h3F80_0000);
        send(32'h4040_0000, 32'h3F80_0000);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_vld", 64'(out_vld), 64'd0);
        check("mid_rst_out", 64'(pack_out()), 64'd0);
        check("mid_rst_in_rdy", 64'(in_rdy), 64'd1);
        repeat (5) @(posedge clk);
        #1;

        // Randomized traffic with random backpressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            rand_ops(a, b);
            send(a, b);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        out_rdy = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("final_drain", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("final_idle", 64'(out_vld), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_align_stage.md
FP_ALIGN_STAGE -- requirements
Module: fp_align_stage

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 op_a  input  32  IEEE-754 single operand A.
REQ-004 op_b  input  32  IEEE-754 single operand B.
REQ-005 in_vld  input  1  op_a/op_b valid.
REQ-006 in_rdy  output  1  stage can accept; transfer when in_vld & in_rdy.
REQ-007 out_vld  output  1  aligned result valid.
REQ-008 out_rdy  input  1  downstream accepts; transfer when out_vld & out_rdy.
REQ-009 exp_big  output  8  exponent of larger-magnitude operand.
REQ-010 sign_big, sign_small  output  1 each  signs of larger and smaller operand.
REQ-011 mant_big  output  24  larger operand mantissa, hidden bit at [23].
REQ-012 mant_small  output  24  smaller operand mantissa, hidden bit included, right-shifted by exponent difference.
REQ-013 sticky  output  1  OR of all mant_small bits shifted out.

Function
REQ-014 Two-stage pipeline: S1 registers compare/swap/shift amount; S2 registers shifted mantissa and sticky.
REQ-015 Latency exactly 2 cycles from input transfer to out_vld with out_rdy held high; throughput 1 op/cycle.
REQ-016 Operand with exponent field 0 (zero/denormal) is flushed: mantissa = 0, exponent = 0, sign retained.
REQ-017 Hidden bit = 1 for nonzero exponent field; mantissa = {hidden, frac[22:0]}.
REQ-018 Big/small order: larger exponent is big; equal exponents -> larger fraction is big; fully equal magnitude -> A is big.
REQ-019 Shift amount = exp_big - exp_small (8-bit unsigned, never negative per REQ-018).
REQ-020 Shift amount >= 24: mant_small = 0, sticky = OR of entire unshifted small mantissa.
REQ-021 Shift amount 0: mant_small = unshifted small mantissa, sticky = 0.
REQ-022 Shift is logical right (zero fill); sticky = OR of the shift-amount low-order bits discarded.
REQ-023 Each stage holds a valid bit; stage advances when its next stage is empty or draining in the same cycle.
REQ-024 in_rdy = !S1_vld | (S1 advancing into S2 this cycle); combinational from out_rdy allowed.
REQ-025 While out_vld & !out_rdy, all S2 outputs held stable; S1 holds if full.
REQ-026 Simultaneous accept into S1 and drain from S2 in one cycle: no data loss or duplication.
REQ-027 Payload registers update only on stage advance; valid bits clear when drained with no replacement.
REQ-028 NaN/Inf inputs not special-cased; exponent 0xFF processed arithmetically as any other value.

Reset
REQ-029 On rst, S1_vld = S2_vld = 0 next edge; out_vld = 0; exp_big, mant_big, mant_small, sign_big, sign_small, sticky = 0.
REQ-030 in_rdy = 1 in the first cycle after rst deasserts.
REQ-031 rst mid-operation discards all in-flight ops; none emerge afterward.
REQ-032 rst overrides simultaneous in_vld/out_rdy activity.

Verification
REQ-033 A=0x3F800000, B=0x40000000, out_rdy=1 -> 2 cycles later: exp_big=0x80, mant_big=0x800000, mant_small=0x400000, sticky=0, sign_big=sign_small=0.
REQ-034 A=0x4B800000, B=0x3F800001 (diff 24) -> mant_big=0x800000, mant_small=0, sticky=1.
REQ-035 A=0x7F000000, B=0xBF800000 (diff 127) -> mant_small=0, sticky=1, sign_small=1, exp_big=0xFE.
REQ-036 A=0x3F800000, B=0x00000001 (denormal) -> mant_small=0, sticky=0, exp_big=0x7F.
REQ-037 Backpressure: 4 back-to-back inputs, out_rdy low cycles 2-5 -> in_rdy low once S1 and S2 full; all 4 results emerge in order, unchanged, no duplicates.
REQ-038 Reset: 2 ops in flight, rst high 1 cycle -> out_vld=0 next cycle, all outputs 0, in_rdy=1, no stale result ever appears.
